// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle TSC control FSM: state encoding,
// datapath mux encodings, ISA opcode/func constants, the control-strobe
// bundle and an instruction classifier used by the FSM decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MEM  = 4'd3,
    S_WB   = 4'd4,
    S_HALT = 4'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,  // ALU result (PC+1)
    PC_SRC_BRANCH = 2'd1,  // alu_out (branch target computed in ID)
    PC_SRC_JUMP   = 2'd2,  // jump target field
    PC_SRC_REG    = 2'd3   // rs register
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_B_RT  = 2'd0,
    ALU_B_ONE = 2'd1,
    ALU_B_IMM = 2'd2
  } alu_b_e;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  // ALU funcs ADD..SHR occupy 0..7; everything above that is special.
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [3:0] {
    C_RTYPE, C_ALU_IMM, C_LOAD, C_STORE, C_BRANCH, C_JMP,
    C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_ILLEGAL
  } inst_class_e;

  typedef struct packed {
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_e pc_src;
    logic    pc_to_reg;
    logic    alu_src_a;
    alu_b_e  alu_src_b;
    logic    alu_op;
    logic    halt;
    logic    wwd;
    logic    illegal_inst;
  } ctrl_t;

  function automatic inst_class_e decode_inst(input logic [3:0] opcode,
                                              input logic [5:0] func_code);
    inst_class_e cls;
    cls = C_ILLEGAL;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls = C_BRANCH;
      OP_ADI, OP_ORI, OP_LHI:         cls = C_ALU_IMM;
      OP_LWD:                         cls = C_LOAD;
      OP_SWD:                         cls = C_STORE;
      OP_JMP:                         cls = C_JMP;
      OP_JAL:                         cls = C_JAL;
      OP_ALU: begin
        case (func_code)
          FN_JPR:  cls = C_JPR;
          FN_JRL:  cls = C_JRL;
          FN_WWD:  cls = C_WWD;
          FN_HLT:  cls = C_HLT;
          default: cls = (func_code <= FN_SHR) ? C_RTYPE : C_ILLEGAL;
        endcase
      end
      default: cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-access wait timer for the control FSM.
//   clk, reset   : clock, synchronous active-high reset
//   active_i     : FSM is in a memory-access state (IF or MEM)
//   mem_ready_i  : memory done strobe, honoured only when USE_READY=1
//   done_o       : this cycle completes the current access
// wcnt counts cycles spent in the current access and returns to zero
// whenever no access is in progress or the access completes, so it is
// always zero on entry to IF or MEM (including MEM -> IF back-to-back).
module mem_wait_timer #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned USE_READY   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic done_o
);

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  logic [3:0] wcnt_q, wcnt_d;

  assign done_o = active_i && ((USE_READY != 0) ? mem_ready_i : (wcnt_q == LAST));

  // NOTE: every variable written in always_comb gets a value before any
  // branch, so no path can leave it holding state and infer a latch.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!active_i || done_o) begin
      wcnt_d = 4'd0;
    end else if (wcnt_q != 4'hF) begin
      // Saturates so an unbounded ready wait cannot wrap the counter.
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops
  // update together at the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= 4'd0;
    else       wcnt_q <= wcnt_d;
  end

endmodule

// File: rtl/mc_ctrl_fsm_param.sv
// Multi-cycle control FSM for the 16-bit TSC CPU with parametrised memory
// latency / ready handshake, sticky halt, illegal-instruction flagging and
// a retired-instruction counter.
//   clk, reset                 : clock, synchronous active-high reset
//   opcode, func_code          : IR[15:12], IR[5:0]
//   bcond                      : branch condition (gates PC load in the datapath)
//   mem_ready                  : memory done, used only when USE_READY=1
//   i_or_d .. alu_op           : datapath control strobes
//   halt, wwd, new_inst,
//   illegal_inst               : status flags / pulses
//   state_o                    : current state (debug)
//   inst_count                 : retired instructions, wraps mod 2^COUNT_W
// All outputs are forced to zero while reset is high.
module mc_ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned USE_READY   = 0,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic [5:0]         func_code,
  input  logic               bcond,
  input  logic               mem_ready,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               pc_to_reg,
  output logic               alu_src_A,
  output logic [1:0]         alu_src_B,
  output logic               alu_op,
  output logic               halt,
  output logic               wwd,
  output logic               new_inst,
  output logic               illegal_inst,
  output logic [3:0]         state_o,
  output logic [COUNT_W-1:0] inst_count
);

  state_e               state_q, state_d;
  logic                 first_q;
  logic [COUNT_W-1:0]   cnt_q;
  logic                 mem_done;
  logic                 enter_if, enter_halt;
  inst_class_e          cls;
  ctrl_t                ctrl, ctrl_out;

  mem_wait_timer #(
    .MEM_LATENCY(MEM_LATENCY),
    .USE_READY  (USE_READY)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .active_i   ((state_q == S_IF) || (state_q == S_MEM)),
    .mem_ready_i(mem_ready),
    .done_o     (mem_done)
  );

  // bcond is consumed by the datapath (pc_write_cond AND bcond), not here.
  assign cls = decode_inst(opcode, func_code);

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALU_B_ONE;
        if (mem_done) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_ID;
        end
      end
      S_ID: begin
        state_d = S_IF;
        case (cls)
          C_JMP, C_JAL: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_src    = PC_SRC_JUMP;
            ctrl.reg_write = (cls == C_JAL);
            ctrl.pc_to_reg = (cls == C_JAL);
          end
          C_JPR, C_JRL: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_src    = PC_SRC_REG;
            ctrl.reg_write = (cls == C_JRL);
            ctrl.pc_to_reg = (cls == C_JRL);
          end
          C_WWD:     ctrl.wwd = 1'b1;
          C_HLT:     state_d = S_HALT;
          C_ILLEGAL: ctrl.illegal_inst = 1'b1;
          C_BRANCH: begin
            // Branch target PC+imm is latched into alu_out for use in EX.
            ctrl.alu_src_b = ALU_B_IMM;
            state_d        = S_EX;
          end
          default:   state_d = S_EX;
        endcase
      end
      S_EX: begin
        state_d = S_WB;
        case (cls)
          C_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 1'b1;
          end
          C_ALU_IMM: begin
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = 1'b1;
          end
          C_LOAD, C_STORE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_B_IMM;
            state_d        = S_MEM;
          end
          default: begin
            ctrl.alu_op        = 1'b1;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PC_SRC_BRANCH;
            state_d            = S_IF;
          end
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls == C_LOAD);
        ctrl.mem_write = (cls == C_STORE);
        if (mem_done) state_d = (cls == C_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (cls == C_LOAD);
        state_d         = S_IF;
      end
      S_HALT:  ctrl.halt = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  assign enter_if   = (state_d == S_IF)   && (state_q != S_IF);
  assign enter_halt = (state_d == S_HALT) && (state_q != S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= enter_if;
      if (enter_if || enter_halt) cnt_q <= cnt_q + COUNT_W'(1);
    end
  end

  // Reset gates the outputs combinationally so a store in flight stops in
  // the same cycle reset is seen, not one edge later.
  assign ctrl_out      = reset ? '0 : ctrl;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_write     = ctrl_out.reg_write;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_src        = ctrl_out.pc_src;
  assign pc_to_reg     = ctrl_out.pc_to_reg;
  assign alu_src_A     = ctrl_out.alu_src_a;
  assign alu_src_B     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign halt          = ctrl_out.halt;
  assign wwd           = ctrl_out.wwd;
  assign illegal_inst  = ctrl_out.illegal_inst;
  assign new_inst      = !reset && first_q && (state_q == S_IF);
  assign state_o       = reset ? 4'd0 : state_q;
  assign inst_count    = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm_param.sv
// Four controller instances with different latency / handshake / counter
// widths run independent instruction programs. A per-instruction model
// expands each instruction into its expected cycle-by-cycle outputs.
module tb_mc_ctrl_fsm_param;

  localparam int N = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 3;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int rdy_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction

  function automatic int cw_of(input int g);
    return (g == 1) ? 3 : 16;
  endfunction

  typedef struct packed {
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       pc_to_reg;
    logic       alu_src_A;
    logic [1:0] alu_src_B;
    logic       alu_op;
    logic       halt;
    logic       wwd;
    logic       new_inst;
    logic       illegal_inst;
    logic [3:0] state;
  } obs_t;

  typedef struct packed {
    logic        r;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic        bc;
    logic        rdy;
    obs_t        e;
    logic [15:0] cnt;
  } step_t;

  logic        clk = 1'b0;
  logic        rst [N];
  logic [3:0]  op  [N];
  logic [5:0]  fn  [N];
  logic        bc  [N];
  logic        rdy [N];
  obs_t        obs [N];
  logic [15:0] cnt_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = cw_of(g);
    obs_t         o;
    logic [W-1:0] cnt_l;
    mc_ctrl_fsm_param #(
      .MEM_LATENCY(lat_of(g)),
      .USE_READY  (rdy_of(g)),
      .COUNT_W    (W)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .opcode(op[g]), .func_code(fn[g]),
      .bcond(bc[g]), .mem_ready(rdy[g]),
      .i_or_d(o.i_or_d), .mem_read(o.mem_read), .mem_write(o.mem_write),
      .ir_write(o.ir_write), .mem_to_reg(o.mem_to_reg), .reg_write(o.reg_write),
      .pc_write(o.pc_write), .pc_write_cond(o.pc_write_cond), .pc_src(o.pc_src),
      .pc_to_reg(o.pc_to_reg), .alu_src_A(o.alu_src_A), .alu_src_B(o.alu_src_B),
      .alu_op(o.alu_op), .halt(o.halt), .wwd(o.wwd), .new_inst(o.new_inst),
      .illegal_inst(o.illegal_inst), .state_o(o.state), .inst_count(cnt_l)
    );
    assign obs[g]   = o;
    assign cnt_o[g] = 16'(cnt_l);
  end

  // ---------------- model ----------------
  step_t      q [N][$];
  int         mcnt [N];
  logic [3:0] c_op [N];
  logic [5:0] c_fn [N];
  logic       c_bc [N];

  int vectors = 0;
  int miscompares = 0;

  task automatic push(input int g, input logic r, input logic rd, input obs_t e);
    step_t s;
    s.r   = r;
    s.op  = c_op[g];
    s.fn  = c_fn[g];
    s.bc  = c_bc[g];
    s.rdy = rd;
    s.e   = r ? '0 : e;
    s.cnt = r ? 16'd0 : 16'(mcnt[g] % (1 << cw_of(g)));
    q[g].push_back(s);
  endtask

  task automatic do_reset(input int g, input int n);
    mcnt[g] = 0;
    for (int i = 0; i < n; i++) push(g, 1'b1, 1'b1, '0);
  endtask

  // One memory access of n cycles (instruction fetch or data access).
  task automatic access(input int g, input bit is_if, input bit ld, input bit st, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (is_if) begin
        e.state     = 4'd0;
        e.mem_read  = 1'b1;
        e.alu_src_B = 2'd1;
        e.new_inst  = (i == 0);
        e.ir_write  = (i == n - 1);
        e.pc_write  = (i == n - 1);
      end else begin
        e.state     = 4'd3;
        e.i_or_d    = 1'b1;
        e.mem_read  = ld;
        e.mem_write = st;
      end
      push(g, 1'b0, (rdy_of(g) != 0) ? (i == n - 1) : 1'b1, e);
    end
  endtask

  // w: access length for the ready-handshake instance; abort: reset after
  // this many MEM cycles (0 = no abort).
  task automatic run_inst(input int g, input int opc, input int fnc, input bit bcnd,
                          input int w, input int abort);
    obs_t e;
    int   n;
    bit   to_ex, to_halt, ld, st;
    c_op[g] = 4'(opc);
    c_fn[g] = 6'(fnc);
    c_bc[g] = bcnd;
    n  = (rdy_of(g) != 0) ? w : lat_of(g);
    ld = (opc == 7);
    st = (opc == 8);
    access(g, 1'b1, 1'b0, 1'b0, n);
    // ID
    e = '0; e.state = 4'd1; to_ex = 0; to_halt = 0;
    if (opc == 9 || opc == 10) begin
      e.pc_write = 1'b1; e.pc_src = 2'd2;
      e.reg_write = (opc == 10); e.pc_to_reg = (opc == 10);
    end else if (opc == 15) begin
      if (fnc == 25) begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
      else if (fnc == 26) begin
        e.pc_write = 1'b1; e.pc_src = 2'd3; e.reg_write = 1'b1; e.pc_to_reg = 1'b1;
      end
      else if (fnc == 28) e.wwd = 1'b1;
      else if (fnc == 29) to_halt = 1;
      else if (fnc <= 7) to_ex = 1;
      else e.illegal_inst = 1'b1;
    end else if (opc >= 11) begin
      e.illegal_inst = 1'b1;
    end else begin
      if (opc <= 3) e.alu_src_B = 2'd2;
      to_ex = 1;
    end
    push(g, 1'b0, 1'b1, e);
    if (to_halt) begin
      mcnt[g]++;
      c_op[g] = 4'd9;  // inputs are irrelevant once halted
      for (int i = 0; i < 4; i++) begin
        e = '0; e.halt = 1'b1; e.state = 4'd5;
        c_bc[g] = i[0];
        push(g, 1'b0, i[1], e);
      end
      return;
    end
    if (!to_ex) begin mcnt[g]++; return; end
    // EX
    e = '0; e.state = 4'd2;
    if (opc == 15) begin e.alu_src_A = 1'b1; e.alu_op = 1'b1; end
    else if (opc >= 4 && opc <= 6) begin e.alu_src_B = 2'd2; e.alu_op = 1'b1; end
    else if (ld || st) begin e.alu_src_A = 1'b1; e.alu_src_B = 2'd2; end
    else begin e.alu_op = 1'b1; e.pc_write_cond = 1'b1; e.pc_src = 2'd1; end
    push(g, 1'b0, 1'b1, e);
    if (opc <= 3) begin mcnt[g]++; return; end
    if (ld || st) begin
      if (abort > 0) begin
        access(g, 1'b0, ld, st, abort);
        do_reset(g, 1);
        return;
      end
      access(g, 1'b0, ld, st, n);
      if (st) begin mcnt[g]++; return; end
    end
    // WB
    e = '0; e.state = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = ld;
    push(g, 1'b0, 1'b1, e);
    mcnt[g]++;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  int ni [N][$];    // cycles where the DUT raised new_inst
  int ill_seen [N];
  int halt_cnt [N];

  function automatic int gap(input int g, input int k);
    if (ni[g].size() > k + 1) return ni[g][k+1] - ni[g][k];
    return -1;
  endfunction

  initial begin
    step_t cur [N];
    bit    act [N];
    bit    busy;
    int    cyc;
    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1; op[g] = '0; fn[g] = '0; bc[g] = 1'b0; rdy[g] = 1'b0;
      mcnt[g] = 0; c_op[g] = '0; c_fn[g] = '0; c_bc[g] = 1'b0;
      ill_seen[g] = 0; halt_cnt[g] = -1;
      do_reset(g, 2);
    end
    // A: latency 3
    run_inst(0, 15, 0, 0, 0, 0);   // ADD
    run_inst(0, 5, 0, 0, 0, 0);    // ORI
    run_inst(0, 9, 0, 0, 0, 0);    // JMP
    do_reset(0, 1);
    // B: latency 2, 3-bit counter
    run_inst(1, 7, 0, 0, 0, 0);    // LWD
    run_inst(1, 8, 0, 0, 0, 0);    // SWD
    run_inst(1, 1, 0, 0, 0, 0);    // BEQ bcond=0
    run_inst(1, 1, 0, 1, 0, 0);    // BEQ bcond=1
    run_inst(1, 9, 0, 0, 0, 0);    // JMP
    run_inst(1, 10, 0, 0, 0, 0);   // JAL
    run_inst(1, 15, 26, 0, 0, 0);  // JRL
    run_inst(1, 11, 0, 0, 0, 0);   // undefined opcode
    run_inst(1, 15, 28, 0, 0, 0);  // WWD
    run_inst(1, 4, 0, 0, 0, 0);    // ADI
    run_inst(1, 6, 0, 0, 0, 0);    // LHI
    run_inst(1, 15, 25, 0, 0, 0);  // JPR
    run_inst(1, 15, 29, 0, 0, 0);  // HLT
    do_reset(1, 2);
    run_inst(1, 8, 0, 0, 0, 1);    // SWD, reset after 1 MEM cycle
    run_inst(1, 15, 1, 0, 0, 0);   // SUB
    do_reset(1, 1);
    // C: ready handshake
    run_inst(2, 15, 0, 0, 6, 0);   // ADD, ready after 5 low cycles
    run_inst(2, 7, 0, 0, 3, 0);    // LWD
    run_inst(2, 0, 0, 1, 1, 0);    // BNE
    do_reset(2, 1);
    // D: latency 1
    run_inst(3, 15, 2, 0, 0, 0);   // AND
    run_inst(3, 7, 0, 0, 0, 0);    // LWD
    run_inst(3, 8, 0, 0, 0, 0);    // SWD
    run_inst(3, 0, 0, 0, 0, 0);    // BNE
    run_inst(3, 15, 8, 0, 0, 0);   // undefined func
    do_reset(3, 1);

    cyc  = 0;
    busy = 1;
    while (busy) begin
      @(negedge clk);
      busy = 0;
      for (int g = 0; g < N; g++) begin
        act[g] = (q[g].size() > 0);
        if (act[g]) begin
          cur[g] = q[g].pop_front();
          rst[g] = cur[g].r; op[g] = cur[g].op; fn[g] = cur[g].fn;
          bc[g]  = cur[g].bc; rdy[g] = cur[g].rdy;
          busy   = 1;
        end else begin
          rst[g] = 1'b1;
        end
      end
      #1;
      for (int g = 0; g < N; g++) begin
        if (act[g]) begin
          vectors++;
          if (obs[g] !== cur[g].e || cnt_o[g] !== cur[g].cnt) begin
            miscompares++;
            $display("FAIL dut%0d cycle %0d: outputs=%h count=%0d, expected outputs=%h count=%0d",
                     g, cyc, obs[g], cnt_o[g], cur[g].e, cur[g].cnt);
          end
          if (obs[g].new_inst === 1'b1) ni[g].push_back(cyc);
          if (obs[g].illegal_inst === 1'b1) ill_seen[g]++;
          if (obs[g].halt === 1'b1) halt_cnt[g] = int'(cnt_o[g]);
        end
      end
      cyc++;
    end

    // Hand-computed instruction lengths and counts.
    check("A_add_len_lat3", gap(0, 0), 6);
    check("A_ori_len_lat3", gap(0, 1), 6);
    check("B_lwd_len_lat2", gap(1, 0), 7);
    check("B_swd_len_lat2", gap(1, 1), 6);
    check("B_beq_len_lat2", gap(1, 2), 4);
    check("B_illegal_pulses", ill_seen[1], 1);
    check("B_count_in_halt_wrapped", halt_cnt[1], 5);
    check("C_add_len_ready", gap(2, 0), 9);
    check("D_and_len_lat1", gap(3, 0), 4);
    check("D_lwd_len_lat1", gap(3, 1), 5);
    check("D_swd_len_lat1", gap(3, 2), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
